data_mem_wait: RTL and testbench
================================

// Module: data_mem_wait
// PURPOSE
//  Parametrised data memory for the MEM stage of the pipelined ARM core; successor to the single-cycle data memory.
//  - Adds configurable wait states, byte and word access, and out-of-range detection.
//  - Drives a freeze signal that stalls the pipeline until each access completes.
//  - Subtracts BASE_ADDR from the ALU result and indexes words by (addr-BASE_ADDR)>>2.
// PARAMETERS
//  DATA_W          32    data width; must equal 32 (4 byte lanes)
//  ADDR_W          32    address width of alu_res
//  DEPTH           2048  number of DATA_W words stored
//  BASE_ADDR       1024  byte address mapped to word 0
//  WAIT_CYCLES     4     cycles spent in BUSY per access; legal range 1..255
//  CLEAR_ON_RESET  1     1: rst zeroes every word; 0: contents kept across rst
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  alu_res    in   ADDR_W  byte address of the access
//  val_rm     in   DATA_W  store data; byte stores use bits [7:0]
//  mem_w_en   in   1       store request; held until ready
//  mem_r_en   in   1       load request; held until ready
//  byte_en    in   1       1: byte access (LDRB/STRB); 0: word access
//  res_data   out  DATA_W  registered load result
//  ready      out  1       one-cycle completion pulse
//  err        out  1       one-cycle pulse with ready when the address is out of range
//  freeze     out  1       pipeline stall = (mem_r_en|mem_w_en) & ~ready (combinational)
// BEHAVIOUR
//  - Reset values: state IDLE, cnt 0, res_data 0, ready 0, err 0. freeze follows its inputs.
//  - Reset mid-access: returns to IDLE and the pending store is dropped.
//  - States:
//    IDLE -> BUSY when mem_r_en|mem_w_en. Latch addr, wdata, byte_en and op; cnt <= WAIT_CYCLES-1.
//    BUSY with cnt!=0: cnt--. With cnt==0: perform the access at this edge, then go to DONE.
//    DONE: ready=1 for one cycle, then IDLE unconditionally. The pipeline advances on this edge.
//  - Latency: request sampled in cycle 0; ready is high in cycle WAIT_CYCLES+1. Back-to-back accesses are WAIT_CYCLES+2 cycles apart.
//  - Simultaneous mem_w_en and mem_r_en: treated as a store; res_data is unchanged.
//  - Address: off = alu_res - BASE_ADDR (ADDR_W-bit wraparound); idx = off>>2.
//    - Out of range when alu_res < BASE_ADDR or idx >= DEPTH.
//    - Out of range: no write, res_data <= 0, err=1 in the DONE cycle.
//  - Word access: off[1:0] is ignored (address aligned down).
//  - Byte access: lane = off[1:0].
//    - Store writes only that lane.
//    - Load returns the lane zero-extended to DATA_W.
//  - res_data is updated only when a load completes and holds its value otherwise.
//  - Inputs are ignored outside IDLE; latched values are used for the whole access.
// STRUCTURE
//  - Package mem_pkg: state enum {IDLE, BUSY, DONE} (2-bit); constants LANES=4 and LANE_W=8; function for the word index.
//  - Sub-module mem_array: DEPTH x DATA_W storage.
//    - Synchronous write with a 4-bit lane mask; combinational read; async clear gated by CLEAR_ON_RESET.
//  - The top level holds the FSM, counter, latches and range check.
// TESTING
//  1. Word store then load: STR 0xDEADBEEF @1032, then LDR @1032 -> ready at cycle 5 of each access; res_data=0xDEADBEEF; freeze high cycles 0-4.
//  2. Byte store @1033 val_rm=0x000000AA over word 0x11223344 @1032 -> LDR reads 0x1122AA44; LDRB @1033 reads 0x000000AA.
//  3. Out of range: LDR @1020 and LDR @1024+4*2048 -> err=1 with ready; res_data=0. STR @1020 -> no word changes.
//  4. Reset in BUSY during STR 0x55 @1040 -> state IDLE, ready=0; later load @1040 returns 0 with CLEAR_ON_RESET=1.
//  5. mem_w_en & mem_r_en together with 0x77 @1048 -> word written 0x77; res_data keeps its prior value.
//  6. WAIT_CYCLES=1 with 3 back-to-back loads -> ready in cycles 2, 5, 8; alu_res changes while BUSY are ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the wait-state data memory of the MEM stage.
// The FSM state, lane geometry and word-index arithmetic live here so the top and the array agree.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Index arithmetic is carried out at a fixed width wide enough for any ADDR_W up to 64.
    localparam int CALC_W = 64;

    function automatic logic [CALC_W-1:0] word_index(input logic [CALC_W-1:0] off);
        return off >> 2;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with a per-lane write mask and a combinational read port.
// When CLEAR_ON_RESET is 1, the asynchronous reset zeroes every word.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 2048,
    parameter int IDX_W          = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [LANES-1:0]  lane_mask,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (we) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_mask[l]) begin
                            mem_q[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end else begin : g_keep
            // Contents survive reset, so rst plays no part in this storage.
            always_ff @(posedge clk) begin
                if (we) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_mask[l]) begin
                            mem_q[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/data_mem_wait.sv
// MEM-stage data memory with WAIT_CYCLES wait states, byte/word access and range checking.
// freeze stalls the pipeline until the one-cycle ready pulse; the pipeline advances on that edge.
module data_mem_wait
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 2048,
    parameter int BASE_ADDR      = 1024,
    parameter int WAIT_CYCLES    = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              mem_w_en,
    input  logic              mem_r_en,
    input  logic              byte_en,
    output logic [DATA_W-1:0] res_data,
    output logic              ready,
    output logic              err,
    output logic              freeze
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              byte_q, byte_d;
    logic              store_q, store_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic [ADDR_W-1:0] off;
    logic [CALC_W-1:0] idx_full;
    logic [1:0]        lane;
    logic              in_range;
    logic              mem_we;
    logic [LANES-1:0]  mem_mask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_val;

    // Range and lane are derived from the latched address so mid-access input changes are harmless.
    always_comb begin
        off      = addr_q - ADDR_W'(BASE_ADDR);
        idx_full = word_index(CALC_W'(off));
        lane     = off[1:0];
        in_range = (addr_q >= ADDR_W'(BASE_ADDR)) && (idx_full < CALC_W'(DEPTH));
    end

    always_comb begin
        mem_mask  = byte_q ? (LANES'(1) << lane) : {LANES{1'b1}};
        mem_wdata = byte_q ? {LANES{wdata_q[LANE_W-1:0]}} : wdata_q;
        load_val  = byte_q ? DATA_W'(mem_rdata[lane*LANE_W +: LANE_W]) : mem_rdata;
    end

    mem_array #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .IDX_W          (IDX_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_we),
        .lane_mask (mem_mask),
        .addr      (idx_full[IDX_W-1:0]),
        .wdata     (mem_wdata),
        .rdata     (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        store_d = store_q;
        oor_d   = oor_q;
        res_d   = res_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    state_d = BUSY;
                    addr_d  = alu_res;
                    wdata_d = val_rm;
                    byte_d  = byte_en;
                    // A simultaneous read and write request is handled as a store.
                    store_d = mem_w_en;
                    cnt_d   = 8'(WAIT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                    oor_d   = ~in_range;
                    if (store_q) begin
                        mem_we = in_range;
                    end else begin
                        res_d = in_range ? load_val : '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            store_q <= 1'b0;
            oor_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            store_q <= store_d;
            oor_q   <= oor_d;
            res_q   <= res_d;
        end
    end

    assign res_data = res_q;
    assign ready    = (state_q == DONE);
    assign err      = (state_q == DONE) && oor_q;
    assign freeze   = (mem_r_en | mem_w_en) & ~ready;

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed bench for data_mem_wait: a WAIT_CYCLES=4 instance and a WAIT_CYCLES=1 instance.
// Handshake: a request is held until the cycle in which ready is high, then dropped or replaced.
module tb_data_mem_wait;
    import mem_pkg::*;

    logic        clk;
    logic        rst;

    logic [31:0] a_addr, a_data, a_res;
    logic        a_w, a_r, a_b, a_ready, a_err, a_freeze;
    logic [31:0] b_addr, b_data, b_res;
    logic        b_w, b_r, b_b, b_ready, b_err, b_freeze;

    int tests  = 0;
    int failed = 0;

    data_mem_wait #(.WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .alu_res(a_addr), .val_rm(a_data),
        .mem_w_en(a_w), .mem_r_en(a_r), .byte_en(a_b),
        .res_data(a_res), .ready(a_ready), .err(a_err), .freeze(a_freeze)
    );

    data_mem_wait #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .alu_res(b_addr), .val_rm(b_data),
        .mem_w_en(b_w), .mem_r_en(b_r), .byte_en(b_b),
        .res_data(b_res), .ready(b_ready), .err(b_err), .freeze(b_freeze)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                         input logic w, input logic r, input logic b);
        if (sel) begin
            b_addr = addr; b_data = data; b_w = w; b_r = r; b_b = b;
        end else begin
            a_addr = addr; a_data = data; a_w = w; a_r = r; a_b = b;
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic access(input bit sel, input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic w, input logic r, input logic b,
                          input int exp_cyc, output logic [31:0] rd, output logic e);
        int got = -1;
        int fz  = 0;
        rd = '0;
        e  = 1'b0;
        drive(sel, addr, data, w, r, b);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sel ? b_freeze : a_freeze) fz++;
            if (sel ? b_ready : a_ready) begin
                got = c;
                rd  = sel ? b_res : a_res;
                e   = sel ? b_err : a_err;
                break;
            end
            @(posedge clk);
        end
        check({tag, " ready_cycle"}, 32'(got), 32'(exp_cyc));
        check({tag, " freeze_cycles"}, 32'(fz), 32'(exp_cyc));
        @(posedge clk);
        #1;
        drive(sel, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed steps ----------------
    logic [31:0] rd;
    logic        e;
    int          rdy_n;
    logic [31:0] ld_addr [3];
    logic [31:0] ld_exp [3];

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {30'd0, dut.state_q}, {30'd0, IDLE});
        check("reset res_data", a_res, 32'h0);
        check("reset ready", {31'd0, a_ready}, 32'd0);
        check("reset err", {31'd0, a_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle freeze", {31'd0, a_freeze}, 32'd0);

        // 1. word store then load
        access(1'b0, "str1", 32'd1032, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5, rd, e);
        check("str1 err", {31'd0, e}, 32'd0);
        access(1'b0, "ldr1", 32'd1032, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr1 data", rd, 32'hDEADBEEF);

        // 2. byte lanes
        access(1'b0, "str2", 32'd1032, 32'h11223344, 1'b1, 1'b0, 1'b0, 5, rd, e);
        access(1'b0, "strb2", 32'd1033, 32'h000000AA, 1'b1, 1'b0, 1'b1, 5, rd, e);
        access(1'b0, "ldr2", 32'd1032, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr2 data", rd, 32'h1122AA44);
        access(1'b0, "ldrb2", 32'd1033, 32'h0, 1'b0, 1'b1, 1'b1, 5, rd, e);
        check("ldrb2 data", rd, 32'h000000AA);
        access(1'b0, "ldrb3", 32'd1035, 32'h0, 1'b0, 1'b1, 1'b1, 5, rd, e);
        check("ldrb3 data", rd, 32'h00000011);
        access(1'b0, "ldr_unal", 32'd1034, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_unal data", rd, 32'h1122AA44);

        // 3. range boundaries
        access(1'b0, "str_w0", 32'd1024, 32'h11111111, 1'b1, 1'b0, 1'b0, 5, rd, e);
        access(1'b0, "str_last", 32'd9212, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 5, rd, e);
        check("str_last err", {31'd0, e}, 32'd0);
        access(1'b0, "ldr_last", 32'd9212, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_last data", rd, 32'hCAFEF00D);
        access(1'b0, "ldr_low", 32'd1020, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_low err", {31'd0, e}, 32'd1);
        check("ldr_low data", rd, 32'h0);
        access(1'b0, "ldr_mid", 32'd1032, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        access(1'b0, "ldr_high", 32'd9216, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_high err", {31'd0, e}, 32'd1);
        check("ldr_high data", rd, 32'h0);
        access(1'b0, "str_low", 32'd1020, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5, rd, e);
        check("str_low err", {31'd0, e}, 32'd1);
        access(1'b0, "ldr_w0", 32'd1024, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_w0 data", rd, 32'h11111111);
        check("ldr_w0 err", {31'd0, e}, 32'd0);
        access(1'b0, "ldr_w2", 32'd1032, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_w2 data", rd, 32'h1122AA44);

        // 4. reset while BUSY
        drive(1'b0, 32'd1040, 32'h00000055, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre-reset state", {30'd0, dut.state_q}, {30'd0, BUSY});
        rst = 1'b1;
        #1;
        check("rst busy state", {30'd0, dut.state_q}, {30'd0, IDLE});
        check("rst busy ready", {31'd0, a_ready}, 32'd0);
        check("rst busy res", a_res, 32'h0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, "ldr_rst", 32'd1040, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_rst data", rd, 32'h0);
        access(1'b0, "ldr_clr", 32'd1024, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr_clr data", rd, 32'h0);

        // 5. simultaneous store and load requests
        access(1'b0, "str5", 32'd1052, 32'h12345678, 1'b1, 1'b0, 1'b0, 5, rd, e);
        access(1'b0, "ldr5", 32'd1052, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr5 data", rd, 32'h12345678);
        access(1'b0, "both5", 32'd1048, 32'h00000077, 1'b1, 1'b1, 1'b0, 5, rd, e);
        check("both5 res kept", rd, 32'h12345678);
        access(1'b0, "ldr5b", 32'd1048, 32'h0, 1'b0, 1'b1, 1'b0, 5, rd, e);
        check("ldr5b data", rd, 32'h00000077);

        // 6. WAIT_CYCLES=1, back-to-back loads with address noise while BUSY
        access(1'b1, "w1_st0", 32'd1024, 32'h000000A1, 1'b1, 1'b0, 1'b0, 2, rd, e);
        access(1'b1, "w1_st1", 32'd1028, 32'h000000B2, 1'b1, 1'b0, 1'b0, 2, rd, e);
        access(1'b1, "w1_st2", 32'd1032, 32'h000000C3, 1'b1, 1'b0, 1'b0, 2, rd, e);
        ld_addr[0] = 32'd1024; ld_addr[1] = 32'd1028; ld_addr[2] = 32'd1032;
        ld_exp[0]  = 32'hA1;   ld_exp[1]  = 32'hB2;   ld_exp[2]  = 32'hC3;
        rdy_n = 0;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) drive(1'b1, ld_addr[c/3], '0, 1'b0, 1'b1, 1'b0);
            else            drive(1'b1, 32'd1040, '0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (c % 3 == 2) begin
                check($sformatf("b2b ready c%0d", c), {31'd0, b_ready}, 32'd1);
                check($sformatf("b2b data c%0d", c), b_res, ld_exp[c/3]);
            end
            if (b_ready) rdy_n++;
            @(posedge clk);
            #1;
        end
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        check("b2b ready count", 32'(rdy_n), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
